// File: rtl/fruit_slice_scorer.sv
// ============================================================================
// Module   : fruit_slice_scorer
// Purpose  : Click-to-slice hit detection, score, lives and game-over control
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fruit_slice_scorer #(
    parameter int FRUIT_SIZE      = 32,
    parameter int LIVES           = 3,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_start,
    input  logic       frame_tick,
    input  logic [9:0] fruitX,
    input  logic [9:0] fruitY,
    input  logic       fruit_valid,
    input  logic       fruit_missed,
    input  logic [7:0] mouse_x,
    input  logic [7:0] mouse_y,
    input  logic       mouse_click,
    output logic       remove_fruit,
    output logic [5:0] number_of_fruits_cut,
    output logic [1:0] lives_left,
    output logic       GG
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ARMED    = 3'd1;
    localparam logic [2:0] c_HIT      = 3'd2;
    localparam logic [2:0] c_COOLDOWN = 3'd3;
    localparam logic [2:0] c_OVER     = 3'd4;

    localparam int               c_CNT_W   = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [c_CNT_W-1:0] c_CD_LOAD = c_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [10:0]      c_SIZE    = 11'(FRUIT_SIZE);
    localparam logic [1:0]       c_LIVES   = 2'(LIVES);
    localparam logic [5:0]       c_SCORE_MAX = 6'd63;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               r_click_rise;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_remove;
    logic               r_gg;
    logic [5:0]         r_score;
    logic [1:0]         r_lives;
    logic               w_lives_dec;
    logic               w_restart;
    logic [10:0]        w_sx;
    logic [10:0]        w_sy;
    logic               w_hit;

    // Mouse coordinates are half resolution; widen everything to 11 bits so
    // the far edge of the box never wraps.
    assign w_sx  = {2'b00, mouse_x, 1'b0};
    assign w_sy  = {2'b00, mouse_y, 1'b0};
    assign w_hit = fruit_valid
                 && (w_sx >= {1'b0, fruitX}) && (w_sx < ({1'b0, fruitX} + c_SIZE))
                 && (w_sy >= {1'b0, fruitY}) && (w_sy < ({1'b0, fruitY} + c_SIZE));

    assign w_restart = game_start && ((r_state == c_IDLE) || (r_state == c_OVER));

    always_comb begin
        w_next      = r_state;
        w_lives_dec = 1'b0;
        case (r_state)
            c_IDLE:  if (game_start) w_next = c_ARMED;
            c_ARMED: begin
                // A qualifying slice swallows a simultaneous miss.
                if (r_click_rise && w_hit) w_next = c_HIT;
                else if (fruit_missed)     w_lives_dec = 1'b1;
            end
            c_HIT: begin
                w_next      = c_COOLDOWN;
                w_lives_dec = fruit_missed;
            end
            c_COOLDOWN: begin
                if (r_cnt == '0) w_next = c_ARMED;
                w_lives_dec = fruit_missed;
            end
            c_OVER:  if (game_start) w_next = c_ARMED;
            default: w_next = c_IDLE;
        endcase
        if (w_lives_dec && (r_lives == 2'd1)) w_next = c_OVER;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_click_rise <= 1'b0;
        end else begin
            r_sync1      <= mouse_click;
            r_sync2      <= r_sync1;
            r_sync3      <= r_sync2;
            r_click_rise <= r_sync2 && !r_sync3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_remove <= 1'b0;
            r_gg     <= 1'b0;
            r_score  <= '0;
            r_lives  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next;
            r_remove <= (w_next == c_HIT);
            r_gg     <= (w_next == c_OVER);

            if (w_restart)
                r_lives <= c_LIVES;
            else if (w_lives_dec && (r_lives != 2'd0))
                r_lives <= r_lives - 2'd1;

            if (w_restart)
                r_score <= '0;
            else if ((r_state == c_HIT) && (r_score != c_SCORE_MAX))
                r_score <= r_score + 6'd1;

            if (r_state == c_HIT)
                r_cnt <= c_CD_LOAD;
            else if ((r_state == c_COOLDOWN) && frame_tick && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign remove_fruit         = r_remove;
    assign number_of_fruits_cut = r_score;
    assign lives_left           = r_lives;
    assign GG                   = r_gg;

endmodule

`default_nettype wire

// File: tb/tb_fruit_slice_scorer.sv
// ============================================================================
// Module   : tb_fruit_slice_scorer
// Purpose  : Directed self-checking bench for fruit_slice_scorer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fruit_slice_scorer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       game_start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] fruitX = 10'd100;
    logic [9:0] fruitY = 10'd100;
    logic       fruit_valid = 1'b1;
    logic       fruit_missed = 1'b0;
    logic [7:0] mouse_x = 8'd55;
    logic [7:0] mouse_y = 8'd55;
    logic       mouse_click = 1'b0;
    logic       remove_fruit;
    logic [5:0] number_of_fruits_cut;
    logic [1:0] lives_left;
    logic       GG;

    int checks   = 0;
    int failures = 0;

    fruit_slice_scorer #(.FRUIT_SIZE(32), .LIVES(3), .COOLDOWN_FRAMES(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .game_start           (game_start),
        .frame_tick           (frame_tick),
        .fruitX               (fruitX),
        .fruitY               (fruitY),
        .fruit_valid          (fruit_valid),
        .fruit_missed         (fruit_missed),
        .mouse_x              (mouse_x),
        .mouse_y              (mouse_y),
        .mouse_click          (mouse_click),
        .remove_fruit         (remove_fruit),
        .number_of_fruits_cut (number_of_fruits_cut),
        .lives_left           (lives_left),
        .GG                   (GG)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_game();
        game_start = 1'b1;
        tick(1);
        game_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick(1);
            frame_tick = 1'b0;
            tick(3);
        end
    endtask

    // Press, hold for 8 cycles, release and let the synchronizer drain.
    task automatic click(output int pulses, output int first_at);
        pulses   = 0;
        first_at = -1;
        mouse_click = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (remove_fruit) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        mouse_click = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (remove_fruit) pulses++;
        end
    endtask

    task automatic test_reset();
        int p, f;
        #2 reset = 1'b0;
        #1;
        checks++; if (remove_fruit !== 1'b0) begin failures++; $display("FAIL rst_remove: got %b expected 0", remove_fruit); end
        checks++; if (number_of_fruits_cut !== 6'd0) begin failures++; $display("FAIL rst_score: got %0d expected 0", number_of_fruits_cut); end
        checks++; if (lives_left !== 2'd0) begin failures++; $display("FAIL rst_lives: got %0d expected 0", lives_left); end
        checks++; if (GG !== 1'b0) begin failures++; $display("FAIL rst_gg: got %b expected 0", GG); end
        tick(3);
        reset = 1'b1;
        tick(2);
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL idle_click: got %0d pulses expected 0", p); end
        checks++; if (lives_left !== 2'd0) begin failures++; $display("FAIL idle_lives: got %0d expected 0", lives_left); end
    endtask

    task automatic test_first_hit();
        int p, f;
        start_game();
        checks++; if (lives_left !== 2'd3) begin failures++; $display("FAIL start_lives: got %0d expected 3", lives_left); end
        checks++; if (GG !== 1'b0) begin failures++; $display("FAIL start_gg: got %b expected 0", GG); end
        click(p, f);
        checks++; if (p != 1) begin failures++; $display("FAIL hit_pulses: got %0d expected 1", p); end
        checks++; if (f != 4) begin failures++; $display("FAIL hit_latency: got %0d expected 4", f); end
        checks++; if (number_of_fruits_cut !== 6'd1) begin failures++; $display("FAIL hit_score: got %0d expected 1", number_of_fruits_cut); end
    endtask

    task automatic test_double_click();
        int p, f;
        frames(2);
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL cooldown_click: got %0d pulses expected 0", p); end
        checks++; if (number_of_fruits_cut !== 6'd1) begin failures++; $display("FAIL cooldown_score: got %0d expected 1", number_of_fruits_cut); end
        frames(2);
        click(p, f);
        checks++; if (p != 1) begin failures++; $display("FAIL rearm_click: got %0d pulses expected 1", p); end
        checks++; if (number_of_fruits_cut !== 6'd2) begin failures++; $display("FAIL rearm_score: got %0d expected 2", number_of_fruits_cut); end
        frames(4);
    endtask

    task automatic test_boundary();
        int p, f;
        mouse_x = 8'd66;
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL x_edge_132: got %0d pulses expected 0", p); end
        mouse_x = 8'd49;
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL x_edge_98: got %0d pulses expected 0", p); end
        mouse_x = 8'd55; mouse_y = 8'd66;
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL y_edge_132: got %0d pulses expected 0", p); end
        mouse_y = 8'd55; fruit_valid = 1'b0;
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL no_fruit: got %0d pulses expected 0", p); end
        fruit_valid = 1'b1;
        checks++; if (number_of_fruits_cut !== 6'd2) begin failures++; $display("FAIL miss_score: got %0d expected 2", number_of_fruits_cut); end
        mouse_x = 8'd65;
        click(p, f);
        checks++; if (p != 1) begin failures++; $display("FAIL x_edge_130: got %0d pulses expected 1", p); end
        frames(4);
        mouse_x = 8'd50;
        click(p, f);
        checks++; if (p != 1) begin failures++; $display("FAIL x_edge_100: got %0d pulses expected 1", p); end
        checks++; if (number_of_fruits_cut !== 6'd4) begin failures++; $display("FAIL edge_score: got %0d expected 4", number_of_fruits_cut); end
        frames(4);
        mouse_x = 8'd55;
    endtask

    task automatic test_hit_and_miss();
        mouse_click = 1'b1;
        tick(3);
        fruit_missed = 1'b1;
        tick(1);
        fruit_missed = 1'b0;
        checks++; if (remove_fruit !== 1'b1) begin failures++; $display("FAIL hm_remove: got %b expected 1", remove_fruit); end
        checks++; if (lives_left !== 2'd3) begin failures++; $display("FAIL hm_lives: got %0d expected 3", lives_left); end
        tick(4);
        mouse_click = 1'b0;
        tick(4);
        checks++; if (number_of_fruits_cut !== 6'd5) begin failures++; $display("FAIL hm_score: got %0d expected 5", number_of_fruits_cut); end
        frames(4);
    endtask

    task automatic test_lives();
        int p, f;
        logic [1:0] exp_l [3] = '{2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 3; i++) begin
            fruit_missed = 1'b1;
            tick(1);
            fruit_missed = 1'b0;
            checks++; if (lives_left !== exp_l[i]) begin failures++; $display("FAIL lives_%0d: got %0d expected %0d", i, lives_left, exp_l[i]); end
            checks++; if (GG !== (i == 2)) begin failures++; $display("FAIL gg_%0d: got %b expected %b", i, GG, (i == 2)); end
            tick(2);
        end
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL over_click: got %0d pulses expected 0", p); end
        checks++; if (number_of_fruits_cut !== 6'd5) begin failures++; $display("FAIL over_score: got %0d expected 5", number_of_fruits_cut); end
        checks++; if (GG !== 1'b1) begin failures++; $display("FAIL over_gg_hold: got %b expected 1", GG); end
        start_game();
        checks++; if (GG !== 1'b0) begin failures++; $display("FAIL restart_gg: got %b expected 0", GG); end
        checks++; if (lives_left !== 2'd3) begin failures++; $display("FAIL restart_lives: got %0d expected 3", lives_left); end
        checks++; if (number_of_fruits_cut !== 6'd0) begin failures++; $display("FAIL restart_score: got %0d expected 0", number_of_fruits_cut); end
    endtask

    task automatic test_saturation();
        int p, f;
        for (int i = 1; i <= 64; i++) begin
            click(p, f);
            frames(4);
            if (i == 63) begin
                checks++; if (number_of_fruits_cut !== 6'd63) begin failures++; $display("FAIL sat_63: got %0d expected 63", number_of_fruits_cut); end
            end
        end
        checks++; if (p != 1) begin failures++; $display("FAIL sat_pulse: got %0d pulses expected 1", p); end
        checks++; if (number_of_fruits_cut !== 6'd63) begin failures++; $display("FAIL sat_hold: got %0d expected 63", number_of_fruits_cut); end
    endtask

    task automatic test_reset_in_hit();
        int p = 0;
        mouse_click = 1'b1;
        tick(4);
        checks++; if (remove_fruit !== 1'b1) begin failures++; $display("FAIL pre_rst_hit: got %b expected 1", remove_fruit); end
        reset = 1'b0;
        #1;
        checks++; if (remove_fruit !== 1'b0) begin failures++; $display("FAIL rst_hit_remove: got %b expected 0", remove_fruit); end
        checks++; if (number_of_fruits_cut !== 6'd0) begin failures++; $display("FAIL rst_hit_score: got %0d expected 0", number_of_fruits_cut); end
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (remove_fruit) p++;
        end
        mouse_click = 1'b0;
        tick(4);
        checks++; if (p != 0) begin failures++; $display("FAIL rst_hit_after: got %0d pulses expected 0", p); end
        checks++; if (lives_left !== 2'd0) begin failures++; $display("FAIL rst_hit_idle: got %0d expected 0", lives_left); end
    endtask

    task automatic test_reset_in_cooldown();
        int p, f;
        start_game();
        click(p, f);
        frames(1);
        reset = 1'b0;
        #1;
        checks++; if ({remove_fruit, number_of_fruits_cut, lives_left, GG} !== 10'd0) begin
            failures++; $display("FAIL rst_cd_outputs: got %b expected 0", {remove_fruit, number_of_fruits_cut, lives_left, GG});
        end
        #2 reset = 1'b1;
        tick(2);
        frames(4);
        click(p, f);
        checks++; if (p != 0) begin failures++; $display("FAIL rst_cd_idle: got %0d pulses expected 0", p); end
        start_game();
        checks++; if (lives_left !== 2'd3) begin failures++; $display("FAIL rst_cd_start: got %0d expected 3", lives_left); end
        click(p, f);
        checks++; if (number_of_fruits_cut !== 6'd1) begin failures++; $display("FAIL rst_cd_hit: got %0d expected 1", number_of_fruits_cut); end
    endtask

    initial begin
        test_reset();
        test_first_hit();
        test_double_click();
        test_boundary();
        test_hit_and_miss();
        test_lives();
        test_saturation();
        test_reset_in_hit();
        test_reset_in_cooldown();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
